// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-source producer controller:
// FSM state codes and the channel-index width helper.
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COMM  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse the cycle after a 0->1
// input level is first sampled; a held level yields one pulse.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rising
);

  logic din_q;
  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      din_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      din_q  <= din;
      prev_q <= din_q;
    end
  end

  assign rising = din_q & ~prev_q;

endmodule

// File: rtl/multi_src_ctrl.sv
// Multi-channel producer controller: selects one producer,
// forwards its data to the buffer and handles stall/drain/switch.
module multi_src_ctrl
  import ctrl_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 16,
  parameter int SWITCH_EN = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            start,
  input  logic                          stop,
  input  logic                          buf_full,
  input  logic                          buf_empty,
  input  logic                          cons_valid,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  output logic [NUM_SRC-1:0]            src_en,
  output logic                          buf_wr_en,
  output logic [DATA_W-1:0]             buf_wr_data,
  output logic [1:0]                    state,
  output logic [idx_width(NUM_SRC)-1:0] active_idx
);

  localparam int IW = idx_width(NUM_SRC);

  typedef logic [IW-1:0] idx_t;

  function automatic idx_t lowest(input logic [NUM_SRC-1:0] m);
    idx_t r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (m[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  logic [NUM_SRC-1:0] start_p;
  logic               stop_p;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_start
    edge_detector u_ed (
      .clock  (clk),
      .reset  (rst),
      .din    (start[g]),
      .rising (start_p[g])
    );
  end

  edge_detector u_stop_ed (
    .clock  (clk),
    .reset  (rst),
    .din    (stop),
    .rising (stop_p)
  );

  state_e             state_q, state_d;
  idx_t               idx_q, idx_d;
  logic               pv_q, pv_d;
  idx_t               pi_q, pi_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] act_oh;
  logic [NUM_SRC-1:0] other_p;

  always_comb begin
    act_oh         = '0;
    act_oh[idx_q]  = 1'b1;
    other_p        = start_p & ~act_oh;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pv_d    = pv_q;
    pi_d    = pi_q;
    unique case (state_q)
      S_IDLE: begin
        if (|start_p) begin
          idx_d   = lowest(start_p);
          state_d = S_COMM;
        end
      end
      S_COMM: begin
        if (stop_p) begin
          state_d = S_DRAIN;
        end else if (buf_full) begin
          state_d = S_WAIT;
        end else if (SWITCH_EN != 0 && |other_p) begin
          pv_d    = 1'b1;
          pi_d    = lowest(other_p);
          state_d = S_DRAIN;
        end
      end
      S_WAIT: begin
        if (stop_p) begin
          state_d = S_DRAIN;
        end else if (!buf_full) begin
          state_d = S_COMM;
        end
      end
      S_DRAIN: begin
        // This cycle's stop/start already shapes the exit decision.
        if (SWITCH_EN != 0) begin
          if (stop_p) begin
            pv_d = 1'b0;
          end else if (|start_p) begin
            pv_d = 1'b1;
            pi_d = lowest(start_p);
          end
        end
        if (buf_empty && !cons_valid) begin
          if (pv_d) begin
            state_d = S_COMM;
            idx_d   = pi_d;
            pv_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    en_d = '0;
    if (state_d == S_COMM) en_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pv_q    <= 1'b0;
      pi_q    <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pv_q    <= pv_d;
      pi_q    <= pi_d;
      en_q    <= en_d;
    end
  end

  assign src_en      = en_q;
  assign state       = state_q;
  assign active_idx  = idx_q;
  assign buf_wr_data = src_data[idx_q*DATA_W +: DATA_W];
  assign buf_wr_en   = (state_q == S_COMM) & src_valid[idx_q]
                     & ~buf_full;

endmodule

// File: doc/multi_src_ctrl.md
MULTI_SRC_CTRL -- requirements
Module: multi_src_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2, number of producer channels (1..8).
REQ-002 Parameter DATA_W, default 16, producer/buffer data width.
REQ-003 Parameter SWITCH_EN, default 0, 1 = a start on another channel during production drains the buffer, then switches to that channel.
REQ-004 Port clk  in  1  single clock; every register SHALL update on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port start  in  NUM_SRC  raw start buttons, one per channel.
REQ-007 Port stop  in  1  raw stop button.
REQ-008 Port buf_full / buf_empty  in  1 each  buffer status.
REQ-009 Port cons_valid  in  1  consumer still holds valid data.
REQ-010 Port src_valid  in  NUM_SRC  per-channel data valid.
REQ-011 Port src_data  in  NUM_SRC*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-012 Port src_en  out  NUM_SRC  per-channel produce enable.
REQ-013 Port buf_wr_en  out  1, buf_wr_data  out  DATA_W  buffer write port.
REQ-014 Port state  out  2  current FSM state code.
REQ-015 Port active_idx  out  max(1,clog2(NUM_SRC))  selected channel.

Function
REQ-016 Each start bit and stop SHALL pass through a rising-edge detector; a raw 0->1 first sampled at edge k SHALL act on the FSM transition at edge k+1; a held level SHALL yield one pulse only.
REQ-017 States: IDLE=0, COMM=1, WAIT=2, DRAIN=3.
REQ-018 IDLE: on any start pulse, latch the lowest-index pulsing channel into active_idx and go to COMM; a stop pulse SHALL be ignored.
REQ-019 COMM priority: stop pulse -> DRAIN; else buf_full=1 -> WAIT; else (SWITCH_EN=1 and a start pulse on a channel != active_idx) -> latch the lowest such index as pending, then DRAIN; otherwise stay.
REQ-020 A start pulse on the active channel in COMM or WAIT SHALL be ignored; with SWITCH_EN=0 all start pulses outside IDLE SHALL be ignored.
REQ-021 WAIT: stop pulse -> DRAIN; else buf_full=0 -> COMM.
REQ-022 DRAIN: when buf_empty=1 and cons_valid=0, go to COMM with active_idx=pending and clear pending if pending is set, else go to IDLE.
REQ-023 DRAIN with SWITCH_EN=1: a start pulse SHALL overwrite pending (lowest index that cycle); a stop pulse SHALL clear pending; stop and start in the same cycle: stop wins.
REQ-024 src_en[i] SHALL be 1 only when state=COMM and i=active_idx (registered, follows state).
REQ-025 buf_wr_en SHALL be combinational: state=COMM and src_valid[active_idx]=1 and buf_full=0; buf_wr_data SHALL be src_data of active_idx, zero latency; a write SHALL never occur when buf_full=1.
REQ-026 Simultaneous stop and buf_full in COMM: stop wins, next state DRAIN.
REQ-027 DRAIN entered with the buffer already empty and cons_valid=0 SHALL exit on the next edge.

Reset
REQ-028 On rst=1 at an edge: state=IDLE, active_idx=0, pending cleared, src_en=0, edge-detector history=0.
REQ-029 Reset mid-operation SHALL abort immediately; buf_wr_en SHALL be 0 from that edge on; no pending switch survives.
REQ-030 A button held high across reset deassertion SHALL produce one pulse, on the first edge with rst=0.

Structure
REQ-031 State codes and the index-width function SHALL live in shared package ctrl_pkg.
REQ-032 The existing edge_detector sub-module SHALL be instantiated NUM_SRC+1 times (ports clock, reset, din, rising); no other sub-modules.

Verification
REQ-033 NUM_SRC=2: pulse start[1] -> active_idx=1, state=COMM two edges later, src_en=2'b10; src_valid[1]=1, data 0x0005 -> buf_wr_en=1, buf_wr_data=0x0005.
REQ-034 In COMM raise buf_full -> WAIT next edge, src_en=0, buf_wr_en=0; drop buf_full -> COMM.
REQ-035 start=2'b11 in same cycle from IDLE -> active_idx=0.
REQ-036 Stop during WAIT -> DRAIN; hold buf_empty=1, cons_valid=1 -> remain DRAIN; cons_valid=0 -> IDLE next edge.
REQ-037 SWITCH_EN=1, active 0 in COMM, pulse start[1] -> DRAIN; buffer empty -> COMM with active_idx=1; repeat with stop in DRAIN -> IDLE.
REQ-038 Assert rst during COMM with src_valid=1 -> next edge state=IDLE, src_en=0, buf_wr_en=0, active_idx=0.
